// File: rtl/pim_dma_cmd_queue_if.sv
// pim_dma_cmd_queue_if
//   Command push bus from the core into the PIM DMA command queue.
//   Signal names are from the queue's point of view (i_ = into the queue).
//   master : core side, drives the command and valid, samples ready
//   slave  : queue side, samples the command and valid, drives ready
interface pim_dma_cmd_queue_if;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_funct3;
  logic [3:0]  i_sel_pim;
  logic [12:0] i_size;
  logic [31:0] i_mem_addr;

  modport master (
    output i_cmd_valid, i_funct3, i_sel_pim, i_size, i_mem_addr,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid, i_funct3, i_sel_pim, i_size, i_mem_addr,
    output o_cmd_ready
  );
endinterface

// File: rtl/pim_dma_cmd_queue.sv
// pim_dma_cmd_queue
//   Upstream feeder of the PIM DMA engine. Buffers PIM custom-instruction
//   commands in an in-order FIFO and issues them one at a time to the DMA as
//   a single-cycle enable pulse, then tracks DMA busy until the transfer ends.
//   Illegal commands (funct3 000/011 or size 0) are accepted and dropped,
//   setting a sticky error flag.
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   cmd            command push bus (valid/ready + funct3/sel_pim/size/mem_addr)
//   o_dma_en       one-cycle issue pulse to the DMA
//   o_funct3..o_mem_addr  issued command fields, held until the next issue
//   i_dma_busy     DMA busy status
//   o_cmd_done     one-cycle pulse when the issued command completes
//   o_pending      FIFO occupancy (command in flight not counted)
//   o_idle         fence condition: FIFO empty, no command in flight, DMA idle
//   i_err_clr      clears o_err
//   o_err          sticky illegal-command flag
module pim_dma_cmd_queue #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pim_dma_cmd_queue_if.slave  cmd,
  output logic                o_dma_en,
  output logic [2:0]          o_funct3,
  output logic [3:0]          o_sel_pim,
  output logic [12:0]         o_size,
  output logic [31:0]         o_mem_addr,
  input  logic                i_dma_busy,
  output logic                o_cmd_done,
  output logic [CNT_W-1:0]    o_pending,
  output logic                o_idle,
  input  logic                i_err_clr,
  output logic                o_err
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [2:0]  funct3;
    logic [3:0]  sel_pim;
    logic [12:0] size;
    logic [31:0] mem_addr;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  cmd_t              fifo_q [DEPTH];
  cmd_t              cmd_in;
  cmd_t              issued_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  state_t            state_q, state_d;
  logic              err_q;

  logic full, empty;
  logic push_hs, illegal, push, pop;
  logic dma_en, cmd_done;

  // ---------------------------------------------------------------------------
  // Push side
  // ---------------------------------------------------------------------------
  assign cmd_in = {cmd.i_funct3, cmd.i_sel_pim, cmd.i_size, cmd.i_mem_addr};

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Ready depends only on occupancy: a pop in the same cycle never frees a
  // slot for a push into a full queue.
  assign cmd.o_cmd_ready = !full;

  assign push_hs = cmd.i_cmd_valid && !full;
  assign illegal = (cmd.i_funct3 == 3'b000) || (cmd.i_funct3 == 3'b011) ||
                   (cmd.i_size == 13'd0);
  // Illegal commands still complete the handshake so the core never stalls
  // on them; they just never reach the FIFO.
  assign push    = push_hs && !illegal;

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    dma_en   = 1'b0;
    cmd_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Busy may still be high from a transfer abandoned by reset; wait it out.
        if (!empty && !i_dma_busy) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        dma_en  = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_dma_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!i_dma_busy) begin
          cmd_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  // Storage itself needs no reset: pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) fifo_q[wr_ptr_q] <= cmd_in;
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Issued fields are loaded on pop so they are stable for the whole ISSUE
  // cycle and stay put until the next command is popped.
  always_ff @(posedge i_clk) begin
    if (i_rst)    issued_q <= '0;
    else if (pop) issued_q <= fifo_q[rd_ptr_q];
  end

  // ---------------------------------------------------------------------------
  // Sticky error: a dropped command outranks a same-cycle clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst)                    err_q <= 1'b0;
    else if (push_hs && illegal)  err_q <= 1'b1;
    else if (i_err_clr)           err_q <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_dma_en   = dma_en;
  assign o_cmd_done = cmd_done;
  assign o_funct3   = issued_q.funct3;
  assign o_sel_pim  = issued_q.sel_pim;
  assign o_size     = issued_q.size;
  assign o_mem_addr = issued_q.mem_addr;
  assign o_pending  = count_q;
  assign o_idle     = (state_q == S_IDLE) && empty && !i_dma_busy;
  assign o_err      = err_q;

  // ---------------------------------------------------------------------------
  // Properties
  // ---------------------------------------------------------------------------
  a_en_single: assert property (@(posedge i_clk) disable iff (i_rst)
    o_dma_en |=> !o_dma_en);

  a_count_range: assert property (@(posedge i_clk) disable iff (i_rst)
    count_q <= FULL_CNT);

endmodule
